// File: rtl/mod16_up_counter_if.sv
// Control and status bundle for mod16_up_counter.
// The master drives clr/en/load/load_val. The slave (the counter) returns cnt/tc/wrap/load_err.
interface mod16_up_counter_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output clr, en, load, load_val,
    input  cnt, tc, wrap, load_err
  );

  modport slave (
    input  clr, en, load, load_val,
    output cnt, tc, wrap, load_err
  );
endinterface

// File: rtl/mod16_up_counter.sv
// Synchronous modulo-N up-counter with prescaler, parallel load and registered wrap/load_err pulses.
// Latency: PRESCALE enabled edges per count step. No backpressure. UPCNT_SATURATE_EN makes it hold at MODULUS-1.
module mod16_up_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic               clk,
  input  logic               rst,
  mod16_up_counter_if.slave  bus
);
  localparam int                PW      = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0]     PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0]  CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]    MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             tick;
  logic             load_ok;

  assign tick    = bus.en && (pre_q == PRE_MAX);
  // One extra bit so MODULUS == 2**WIDTH makes every load_val legal.
  assign load_ok = ({1'b0, bus.load_val} < MOD_EXT);

  always_comb begin
    cnt_d  = cnt_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (bus.clr) begin
      cnt_d = '0;
      pre_d = '0;
    end else if (bus.load) begin
      pre_d = '0;
      if (load_ok) begin
        cnt_d = bus.load_val;
      end else begin
        cnt_d = CNT_MAX;
        err_d = 1'b1;
      end
    end else if (bus.en) begin
      if (tick) begin
        pre_d = '0;
        if (cnt_q == CNT_MAX) begin
`ifdef UPCNT_SATURATE_EN
          cnt_d = CNT_MAX;
`else
          cnt_d  = '0;
          wrap_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pre_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.tc       = (cnt_q == CNT_MAX);
  assign bus.wrap     = wrap_q;
  assign bus.load_err = err_q;
endmodule

// File: tb/tb_mod16_up_counter.sv
// Bench for mod16_up_counter: two instances (mod 16 / prescale 1 and mod 10 / prescale 3) share one stimulus stream.
module tb_mod16_up_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod16_up_counter_if #(.WIDTH(4)) bus_a ();
  mod16_up_counter_if #(.WIDTH(4)) bus_b ();

  mod16_up_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  mod16_up_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: count value and number of enabled cycles since the last step.
  int m_mod [2] = '{16, 10};
  int m_pre [2] = '{1, 3};
  int m_cnt [2];
  int m_ph  [2];
  int m_wrap[2];
  int m_err [2];

  task automatic check(string tag, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_ph[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_edge(bit c, bit e, bit l, int v);
    for (int i = 0; i < 2; i++) begin
      m_wrap[i] = 0;
      m_err[i]  = 0;
      if (c) begin
        m_cnt[i] = 0; m_ph[i] = 0;
      end else if (l) begin
        m_ph[i] = 0;
        if (v < m_mod[i]) m_cnt[i] = v;
        else begin m_cnt[i] = m_mod[i] - 1; m_err[i] = 1; end
      end else if (e) begin
        m_ph[i]++;
        if (m_ph[i] == m_pre[i]) begin
          m_ph[i] = 0;
`ifdef UPCNT_SATURATE_EN
          if (m_cnt[i] < m_mod[i] - 1) m_cnt[i]++;
`else
          m_cnt[i]  = (m_cnt[i] + 1) % m_mod[i];
          m_wrap[i] = (m_cnt[i] == 0) ? 1 : 0;
`endif
        end
      end
    end
  endtask

  task automatic check_all(string tag);
    check($sformatf("%s_a_cnt", tag),  int'(bus_a.cnt),      m_cnt[0]);
    check($sformatf("%s_a_tc", tag),   int'(bus_a.tc),       (m_cnt[0] == m_mod[0] - 1) ? 1 : 0);
    check($sformatf("%s_a_wrap", tag), int'(bus_a.wrap),     m_wrap[0]);
    check($sformatf("%s_a_err", tag),  int'(bus_a.load_err), m_err[0]);
    check($sformatf("%s_b_cnt", tag),  int'(bus_b.cnt),      m_cnt[1]);
    check($sformatf("%s_b_tc", tag),   int'(bus_b.tc),       (m_cnt[1] == m_mod[1] - 1) ? 1 : 0);
    check($sformatf("%s_b_wrap", tag), int'(bus_b.wrap),     m_wrap[1]);
    check($sformatf("%s_b_err", tag),  int'(bus_b.load_err), m_err[1]);
  endtask

  task automatic drive(bit c, bit e, bit l, int v);
    logic [3:0] lv;
    lv = v[3:0];
    bus_a.clr = c; bus_a.en = e; bus_a.load = l; bus_a.load_val = lv;
    bus_b.clr = c; bus_b.en = e; bus_b.load = l; bus_b.load_val = lv;
  endtask

  // Apply inputs for the coming edge, advance the model, then check at the falling edge.
  task automatic cycle(string tag, bit c, bit e, bit l, int v);
    drive(c, e, l, v);
    model_edge(c, e, l, v);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int wraps, tcs;
    drive(0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("reset");

    // Free run through a full modulus-16 cycle.
    wraps = 0; tcs = 0;
    for (int i = 0; i < 17; i++) begin
      cycle("free", 0, 1, 0, 0);
      if (bus_a.wrap) wraps++;
      if (bus_a.tc)   tcs++;
`ifndef UPCNT_SATURATE_EN
      if (i == 15) begin
        check("free_a_cnt_at_wrap", int'(bus_a.cnt), 0);
        check("free_a_wrap_at_wrap", int'(bus_a.wrap), 1);
      end
`endif
    end
`ifdef UPCNT_SATURATE_EN
    check("free_wrap_count", wraps, 0);
    check("free_tc_count", tcs, 3);
    check("sat_a_hold", int'(bus_a.cnt), 15);
`else
    check("free_wrap_count", wraps, 1);
    check("free_tc_count", tcs, 1);
`endif

    // Prescaler freeze on instance b.
    cycle("pclr", 1, 0, 0, 0);
    check("sat_clr_a", int'(bus_a.cnt), 0);
    repeat (9) cycle("pre_run", 0, 1, 0, 0);
    check("pre_b_after9", int'(bus_b.cnt), 3);
    cycle("pre_run", 0, 1, 0, 0);
    repeat (5) cycle("pre_hold", 0, 0, 0, 0);
    check("pre_b_frozen", int'(bus_b.cnt), 3);
    cycle("pre_resume", 0, 1, 0, 0);
    check("pre_b_resume1", int'(bus_b.cnt), 3);
    cycle("pre_resume", 0, 1, 0, 0);
    check("pre_b_resume2", int'(bus_b.cnt), 4);

    // Loads: in range, out of range, and load beating a tick.
    cycle("ld7", 0, 0, 1, 7);
    check("ld7_b_cnt", int'(bus_b.cnt), 7);
    check("ld7_b_err", int'(bus_b.load_err), 0);
    cycle("ld12", 0, 0, 1, 12);
    check("ld12_b_cnt", int'(bus_b.cnt), 9);
    check("ld12_b_err", int'(bus_b.load_err), 1);
    check("ld12_a_cnt", int'(bus_a.cnt), 12);
    cycle("ld12_after", 0, 0, 0, 0);
    check("ld12_b_err_drop", int'(bus_b.load_err), 0);
    cycle("ld4", 0, 0, 1, 4);
    cycle("ld4_en", 0, 1, 0, 0);
    cycle("ld4_en", 0, 1, 0, 0);
    cycle("ld_vs_tick", 0, 1, 1, 2);
    check("ld_vs_tick_b", int'(bus_b.cnt), 2);
    check("ld_vs_tick_a", int'(bus_a.cnt), 2);
    cycle("ld_restart", 0, 1, 0, 0);
    cycle("ld_restart", 0, 1, 0, 0);
    check("ld_restart_b_hold", int'(bus_b.cnt), 2);
    cycle("ld_restart", 0, 1, 0, 0);
    check("ld_restart_b_step", int'(bus_b.cnt), 3);

    // Clear outranks load.
    cycle("ld5", 0, 0, 1, 5);
    cycle("clr_ld", 1, 0, 1, 9);
    check("clr_ld_b_cnt", int'(bus_b.cnt), 0);
    check("clr_ld_b_err", int'(bus_b.load_err), 0);

    // Asynchronous reset in the middle of a cycle.
    cycle("ld9", 0, 0, 1, 9);
    drive(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_a_cnt", int'(bus_a.cnt), 0);
    check("arst_b_cnt", int'(bus_b.cnt), 0);
    check("arst_b_wrap", int'(bus_b.wrap), 0);
    check("arst_b_err", int'(bus_b.load_err), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("arst_release");
    cycle("arst_resume", 0, 1, 0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit c, e, l;
      int v;
      c = ($urandom_range(0, 24) == 0);
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 9) < 7);
      v = $urandom_range(0, 15);
      cycle("rand", c, e, l, v);
      check("rand_a_excl", int'(bus_a.wrap & bus_a.load_err), 0);
      check("rand_b_excl", int'(bus_b.wrap & bus_b.load_err), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mod16_up_counter.md
# mod16_up_counter

Synchronous up-counter, the up-counting companion to the team's T-flip-flop ripple down-counter. All state bits change on one clock edge, so `cnt` is glitch-free and safe to sample or decode in the `clk` domain. It adds a programmable modulus, a prescaler, parallel load and a registered wrap pulse. It serves as the event/tick counter for the counter-family testbenches and the surrounding datapath.

## Interface
- Parameters:
  - `WIDTH`, 4: counter width in bits.
  - `MODULUS`, 16: count range 0..MODULUS-1. Legal range 2..2**WIDTH.
  - `PRESCALE`, 1: number of enabled cycles per count step. Legal range 1..256.
- Ports:
  - `clk`  in  1: the single clock. All state updates on its rising edge.
  - `rst`  in  1: asynchronous, active-high reset.
  - `clr`  in  1: synchronous clear.
  - `en`  in  1: count enable. Gates both the prescaler and the counter.
  - `load`  in  1: synchronous parallel load.
  - `load_val`  in  WIDTH: value to load.
  - `cnt`  out  WIDTH: current count, registered.
  - `tc`  out  1: terminal count, combinational, equals (`cnt == MODULUS-1`).
  - `wrap`  out  1: registered one-cycle pulse on wrap-around.
  - `load_err`  out  1: registered one-cycle pulse when `load_val` is out of range.

## Operation
- Internal prescaler `pre`, width clog2(PRESCALE)+1.
  - `tick` = `en` && (`pre == PRESCALE-1`).
  - When `en`=1: `pre` increments, and returns to 0 on `tick`.
  - When `en`=0: `pre` holds its value.
- Per-edge priority, highest first: `rst` > `clr` > `load` > `tick`.
- `rst` (asynchronous): `cnt`=0, `pre`=0, `wrap`=0, `load_err`=0.
- `clr`: `cnt`=0, `pre`=0. No `wrap` pulse.
- `load`:
  - If `load_val` < MODULUS: `cnt`=`load_val`.
  - Otherwise: `cnt`=MODULUS-1 and `load_err`=1 for one cycle.
  - In both cases `pre`=0 and no `wrap` pulse.
- `tick` with `cnt` < MODULUS-1: `cnt`=`cnt`+1.
- `tick` with `cnt` == MODULUS-1: `cnt`=0 and `wrap`=1 on the same edge, held for exactly one cycle.
- Arithmetic is unsigned modulo MODULUS. When MODULUS=2**WIDTH, wrap-around follows natural WIDTH-bit overflow.
- `en` low freezes all counting state. `clr` and `load` still act while `en` is low.
- Simultaneous `load` and `tick`: load wins and the tick is lost. The prescaler restarts from 0.

## Timing
- Latency from `en` rising (with `pre`=0) to the first `cnt` change is PRESCALE edges.
- `cnt`, `wrap` and `load_err` update on the rising edge of `clk`. `tc` follows `cnt` combinationally within the same cycle.
- `wrap` and `tc` never assert together in wrap mode: `tc` asserts in the cycle before the wrap edge, and `wrap` in the cycle after it.
- Reset mid-count:
  - `rst` clears all outputs immediately, without waiting for a clock edge.
  - On `rst` deassertion, counting resumes on the first edge where `tick` is true, starting from 0.
- `load_err` and `wrap` are mutually exclusive in any cycle.

## Configuration
- Macro `UPCNT_SATURATE_EN`.
- When defined:
  - A `tick` at `cnt`=MODULUS-1 holds `cnt`=MODULUS-1.
  - `wrap` is tied to 0.
  - `tc` stays high until `clr`, `load` or `rst`.
- When undefined: the wrap-around behaviour in Operation applies.

## Test plan
- **Reset:** `rst`=1 applied asynchronously mid-cycle, with `cnt`=9 → `cnt`=0, `wrap`=0 and `load_err`=0 before the next edge.
- **Free-run wrap:** MODULUS=16, PRESCALE=1, `en`=1 for 17 edges from 0 → `cnt` runs 1..15, then 0. `tc`=1 only while `cnt`=15. `wrap`=1 for exactly one cycle, the cycle in which `cnt`=0.
- **Prescaler:** PRESCALE=3, MODULUS=10, `en`=1 for 9 edges → `cnt`=3. Deassert `en` for 5 edges → `cnt` stays 3 and `pre` is frozen.
- **Load:**
  - `load_val`=7 with MODULUS=10 → `cnt`=7, `load_err`=0.
  - `load_val`=12 → `cnt`=9, `load_err` pulses once.
  - `load`=1 and `tick`=1 in the same cycle with `cnt`=4, `load_val`=2 → `cnt`=2.
- **Clear priority:** `clr`=1 and `load`=1 together with `cnt`=5 → `cnt`=0, no pulses.
- **Saturate:** build with `UPCNT_SATURATE_EN`, MODULUS=16, run 20 ticks from 0 → `cnt` holds at 15, `tc`=1, `wrap` never asserts. A subsequent `clr` → `cnt`=0.
